i2s_stream_tx: RTL and testbench

I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

---
 rtl/i2s_pkg.sv | 13 +
 rtl/frame_fifo.sv | 53 +++++
 rtl/i2s_stream_tx.sv | 149 ++++++++++++++
 tb/tb_i2s_stream_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S stream transmitter.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int LJ_MODE_I2S  = 0;  // MSB one BCLK after the LRCLK edge
    localparam int LJ_MODE_LEFT = 1;  // MSB on the LRCLK edge

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of stereo frames; head is visible combinationally, no bypass path.
module frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is not reset; the pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/i2s_stream_tx.sv
// Buffered I2S / left-justified transmitter: BCLK, LRCLK and SDATA are all registers in the clk domain.
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 2,
    parameter int LJ_MODE    = LJ_MODE_I2S
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          BCLK,
    output logic                          LRCLK,
    output logic                          SDATA,
    output logic                          frame_done,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int FRAME_W     = 2 * SAMPLE_W;
    localparam int IDX_W       = $clog2(2 * SLOT_W);
    localparam int DIV_W       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int DATA_OFFSET = (LJ_MODE == LJ_MODE_LEFT) ? 0 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * SLOT_W - 1);

    state_t             state, next_state;
    logic [DIV_W-1:0]   div_cnt;
    logic [IDX_W-1:0]   bit_idx, next_idx;
    logic               started;
    logic [FRAME_W-1:0] frame_q, fifo_head, load_frame;
    logic               fifo_full, fifo_empty;
    logic               div_run, tick, fall, frame_edge;
    logic               start_frame, end_frame, advance;

    frame_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid),
        .push_data ({s_left, s_right}),
        .pop       (start_frame),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign s_ready = !fifo_full;

    // Serial bit for a frame position; left sample occupies slot 0, right sample slot 1.
    function automatic logic slot_bit(input logic [FRAME_W-1:0] frame, input logic [IDX_W-1:0] idx);
        logic [SAMPLE_W-1:0] sample;
        int pos;
        int sample_pos;
        pos = int'(idx);
        if (pos >= SLOT_W) begin
            sample = frame[SAMPLE_W-1:0];
            pos    = pos - SLOT_W;
        end else begin
            sample = frame[FRAME_W-1:SAMPLE_W];
        end
        sample_pos = pos - DATA_OFFSET;
        if (sample_pos < 0 || sample_pos >= SAMPLE_W) return 1'b0;
        sample = sample << sample_pos;
        return sample[SAMPLE_W-1];
    endfunction

    assign div_run    = (state != IDLE);
    assign tick       = div_run && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall       = tick && BCLK;
    assign frame_edge = fall && (!started || bit_idx == LAST_IDX);
    assign next_idx   = bit_idx + 1'b1;
    assign load_frame = fifo_empty ? '0 : fifo_head;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable && fifo_level != '0) next_state = RUN;
            RUN:     if (frame_edge && !enable)      next_state = DRAIN;
            DRAIN:   if (fall)                       next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        end_frame   = 1'b0;
        advance     = 1'b0;
        if (state == RUN) begin
            start_frame = frame_edge && enable;
            end_frame   = frame_edge && started;
            advance     = fall && !frame_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            BCLK       <= 1'b0;
            LRCLK      <= 1'b1;
            SDATA      <= 1'b0;
            started    <= 1'b0;
            bit_idx    <= '0;
            frame_q    <= '0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            frame_done <= end_frame;
            underflow  <= start_frame && fifo_empty;
            if (!div_run) begin
                div_cnt <= '0;
                BCLK    <= 1'b0;
                LRCLK   <= 1'b1;
                SDATA   <= 1'b0;
                started <= 1'b0;
                bit_idx <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) BCLK <= !BCLK;
                if (start_frame) begin
                    frame_q <= load_frame;
                    started <= 1'b1;
                    bit_idx <= '0;
                    LRCLK   <= 1'b0;
                    SDATA   <= slot_bit(load_frame, '0);
                end else if (frame_edge) begin
                    // Leaving the frame for DRAIN: line goes quiet, LRCLK holds the right-slot level.
                    started <= 1'b0;
                    SDATA   <= 1'b0;
                end else if (advance) begin
                    bit_idx <= next_idx;
                    LRCLK   <= (int'(next_idx) >= SLOT_W);
                    SDATA   <= slot_bit(frame_q, next_idx);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Bench for i2s_stream_tx: an I2S and a left-justified instance share stimulus; each instance has a
// scoreboard that rebuilds every serial frame and compares it against the queued samples.
module tb_i2s_stream_tx;
    localparam int BCLK_DIV  = 2;
    localparam int FRAME_CLK = 2 * 32 * 2 * BCLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic [1:0]  s_ready, bclk, lrclk, sdata, frame_done, underflow;
    logic [3:0]  fifo_level [2];
    int          cyc = 0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected SDATA over one 64-bit frame, first bit in bit 63.
    function automatic logic [63:0] exp_sdata(input logic [31:0] lr, input int lj);
        logic [63:0] w;
        int off;
        w   = '0;
        off = (lj != 0) ? 0 : 1;
        for (int i = 0; i < 16; i++) begin
            w[63 - off - i] = lr[31 - i];
            w[31 - off - i] = lr[15 - i];
        end
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mode
        i2s_stream_tx #(
            .SAMPLE_W(16), .SLOT_W(32), .FIFO_DEPTH(8), .BCLK_DIV(BCLK_DIV), .LJ_MODE(g)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .s_left     (s_left),
            .s_right    (s_right),
            .s_valid    (s_valid),
            .s_ready    (s_ready[g]),
            .BCLK       (bclk[g]),
            .LRCLK      (lrclk[g]),
            .SDATA      (sdata[g]),
            .frame_done (frame_done[g]),
            .underflow  (underflow[g]),
            .fifo_level (fifo_level[g])
        );

        logic [31:0] exp_q[$];
        logic        acc = 1'b0;
        logic [31:0] acc_data = '0;
        logic        bclk_prev = 1'b0;
        logic        lr_prev = 1'b1;
        logic [63:0] sd_word = '0;
        logic [63:0] lr_word = '0;
        logic [63:0] exp_word = '0;
        int          nbits = -1;
        int          start_cyc = 0;
        int          first_fall_cyc = -1;
        int          started_cnt = 0;
        int          done_cnt = 0;
        int          checked_cnt = 0;
        int          uf_cnt = 0;
        int          uf_exp = 0;

        always @(posedge clk) begin
            acc      <= s_valid && s_ready[g] && !reset;
            acc_data <= {s_left, s_right};
        end

        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                nbits     = -1;
                bclk_prev = 1'b0;
                lr_prev   = 1'b1;
            end else begin
                if (frame_done[g]) done_cnt++;
                if (underflow[g])  uf_cnt++;
                if (bclk_prev && !bclk[g]) begin
                    if (first_fall_cyc < 0) first_fall_cyc = cyc;
                    if (nbits == 64) begin
                        check($sformatf("m%0d_frame_done", g), frame_done[g], 1);
                        check($sformatf("m%0d_frame_len", g), cyc - start_cyc, FRAME_CLK);
                        check($sformatf("m%0d_sdata", g), sd_word, exp_word);
                        check($sformatf("m%0d_lrclk", g), lr_word, 64'h0000_0000_FFFF_FFFF);
                        checked_cnt++;
                        nbits = -1;
                    end
                    if (!lrclk[g] && lr_prev) begin
                        check($sformatf("m%0d_underflow", g), underflow[g], exp_q.size() == 0);
                        if (exp_q.size() == 0) begin
                            exp_word = '0;
                            uf_exp++;
                        end else begin
                            exp_word = exp_sdata(exp_q.pop_front(), g);
                        end
                        start_cyc = cyc;
                        started_cnt++;
                        nbits = 0;
                    end
                    if (nbits >= 0 && nbits < 64) begin
                        sd_word = {sd_word[62:0], sdata[g]};
                        lr_word = {lr_word[62:0], lrclk[g]};
                        nbits++;
                    end
                    lr_prev = lrclk[g];
                end
                if (acc) exp_q.push_back(acc_data);
                bclk_prev = bclk[g];
            end
        end
    end

    task automatic check_outputs(input string tag, input logic [3:0] lvl);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s_m%0d", tag, i),
                  {bclk[i], lrclk[i], sdata[i], frame_done[i], underflow[i], s_ready[i], fifo_level[i]},
                  {5'b01000, lvl != 4'd8, lvl});
    endtask

    task automatic wait_idle(input string tag, input logic [3:0] lvl);
        logic any_bclk;
        any_bclk = 1'b0;
        repeat (6) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            any_bclk = any_bclk | bclk[0] | bclk[1];
        end
        check({tag, "_bclk_quiet"}, any_bclk, 0);
        check_outputs(tag, lvl);
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        int budget;
        budget = 3000;
        @(posedge clk); #1;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        while (!s_ready[0] && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("push_wait", budget > 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget, base, done0, start0, uf0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 4'd0);
        reset = 1'b0;

        // One frame, then a second frame with nothing buffered.
        push_frame(16'hA5C3, 16'h0F01);
        check("level_one", fifo_level[0], 1);
        base   = cyc;
        enable = 1'b1;
        budget = 1000;
        while (g_mode[0].done_cnt < 1 && budget > 0) begin @(posedge clk); #1; budget--; end
        check("wait_frame1", budget > 0, 1);
        enable = 1'b0;
        check("first_fall_latency", g_mode[0].first_fall_cyc - base, 1 + 2 * BCLK_DIV);
        budget = 600;
        while (g_mode[0].done_cnt < 2 && budget > 0) begin @(posedge clk); #1; budget--; end
        check("wait_frame2", budget > 0, 1);
        check("underflow_once_m0", g_mode[0].uf_cnt, 1);
        check("underflow_once_m1", g_mode[1].uf_cnt, 1);
        wait_idle("idle_a", 4'd0);

        // Fill to capacity with the transmitter stopped; an extra offer must be refused.
        for (int i = 0; i < 8; i++) push_frame(16'($urandom), 16'($urandom));
        check_outputs("full", 4'd8);
        @(posedge clk); #1;
        s_left  = 16'hDEAD;
        s_right = 16'hBEEF;
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_outputs("full_hold", 4'd8);

        // Drain all eight, dropping enable at bit index 10 of the last one.
        done0  = g_mode[0].done_cnt;
        start0 = g_mode[0].started_cnt;
        uf0    = g_mode[0].uf_cnt;
        enable = 1'b1;
        budget = 9 * FRAME_CLK;
        while (!(g_mode[0].started_cnt == start0 + 8 && g_mode[0].nbits == 11) && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
        check("wait_idx10", budget > 0, 1);
        enable = 1'b0;
        budget = 600;
        while (g_mode[0].done_cnt < done0 + 8 && budget > 0) begin @(posedge clk); #1; budget--; end
        check("wait_drain", budget > 0, 1);
        wait_idle("idle_b", 4'd0);
        check("frames_run_b", g_mode[0].started_cnt - start0, 8);
        check("no_underflow_b", g_mode[0].uf_cnt - uf0, 0);

        // Reset in the middle of the left... right slot, at bit index 40.
        push_frame(16'h1234, 16'h5678);
        push_frame(16'h9ABC, 16'hDEF0);
        start0 = g_mode[0].started_cnt;
        done0  = g_mode[0].done_cnt;
        enable = 1'b1;
        budget = 2 * FRAME_CLK;
        while (!(g_mode[0].started_cnt == start0 + 1 && g_mode[0].nbits == 41) && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
        check("wait_idx40", budget > 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_outputs("mid_reset", 4'd0);
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("no_done_after_reset", g_mode[0].done_cnt - done0, 0);
        check_outputs("post_reset", 4'd0);
        enable = 1'b0;

        // Sparse random traffic with the transmitter running: mixes full frames and underflows.
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            s_valid = ($urandom_range(0, 199) == 0);
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
        end
        s_valid = 1'b0;
        enable  = 1'b0;
        repeat (300) @(posedge clk);
        wait_idle("idle_d", 4'(g_mode[0].exp_q.size()));

        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                check("done_pulses_m0", g_mode[0].done_cnt, g_mode[0].checked_cnt);
                check("uf_pulses_m0", g_mode[0].uf_cnt, g_mode[0].uf_exp);
            end else begin
                check("done_pulses_m1", g_mode[1].done_cnt, g_mode[1].checked_cnt);
                check("uf_pulses_m1", g_mode[1].uf_cnt, g_mode[1].uf_exp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
